// File: rtl/hazard_controller.sv
// hazard_controller: load-use, branch and mul/div stall/flush sequencing; HAZARD_PERF_EN adds stall/flush counters
module hazard_controller #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  input  logic [4:0]  rdE,
  input  logic        ResultSrcE0,
  input  logic        PCSrcE,
  input  logic        mdStartE,
  input  logic        mdDone,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushD,
  output logic        FlushE,
  output logic        FlushM,
  output logic        mdGo,
  output logic        mdError,
  output logic [31:0] stallCount,
  output logic [31:0] flushCount
);
  typedef enum logic {RUN, MD_BUSY} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic md_error_q, md_error_d;
  logic busy, timeout, lw_stall, md_hold, branch_flush;
  assign busy = state_q == MD_BUSY;
  assign timeout = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  assign mdError = md_error_q;
  // hazard detection and stall/flush decode; mul/div hold dominates load-use, which dominates branch flush
  always_comb begin
    lw_stall = ResultSrcE0 && rdE != 5'd0 && (rdE == rs1D || rdE == rs2D);
    mdGo = !busy && mdStartE && !md_error_q;
    md_hold = mdGo || (busy && !mdDone && !timeout);
    branch_flush = PCSrcE && !busy && !mdGo;
    StallF = md_hold || lw_stall;
    StallD = md_hold || lw_stall;
    StallE = md_hold;
    FlushM = md_hold;
    FlushE = (lw_stall && !md_hold) || branch_flush;
    FlushD = branch_flush;
  end
  // mul/div sequencing: done beats a coincident timeout, an unanswered timeout latches the error
  always_comb begin
    state_d = mdGo ? MD_BUSY : (busy && (mdDone || timeout)) ? RUN : state_q;
    cnt_d = mdGo ? '0 : busy ? cnt_q + 1'b1 : cnt_q;
    md_error_d = md_error_q || (busy && timeout && !mdDone);
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q <= '0;
      md_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      md_error_q <= md_error_d;
    end
  end
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;
  // perf counters wrap naturally at 2^32
  always_comb begin
    stall_count_d = stall_count_q + {31'd0, StallF};
    flush_count_d = flush_count_q + {31'd0, FlushD || FlushE};
  end
  // perf counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end
  assign stallCount = stall_count_q;
  assign flushCount = flush_count_q;
`else
  assign stallCount = '0;
  assign flushCount = '0;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: scoreboard bench for hazard_controller with a short mul/div timeout
module tb_hazard_controller;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] rs1D, rs2D, rdE;
  logic ResultSrcE0, PCSrcE, mdStartE, mdDone;
  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, mdGo, mdError;
  logic [31:0] stallCount, flushCount;
  hazard_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE),
    .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .mdStartE(mdStartE), .mdDone(mdDone),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
    .FlushM(FlushM), .mdGo(mdGo), .mdError(mdError),
    .stallCount(stallCount), .flushCount(flushCount)
  );
  always #5 clk = ~clk;
  typedef struct {
    string tag;
    logic [7:0] o;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  logic m_busy = 1'b0;
  logic m_err = 1'b0;
  int m_cnt = 0;
  logic [31:0] m_sc = '0;
  logic [31:0] m_fc = '0;
  logic [7:0] last_out;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic ld, input logic pc, input logic st, input logic dn);
    exp_t e;
    logic lw, go, to, hold, fd, fe;
    reset = r; rs1D = a; rs2D = b; rdE = d;
    ResultSrcE0 = ld; PCSrcE = pc; mdStartE = st; mdDone = dn;
    lw = ld && d != 0 && (d == a || d == b);
    go = !m_busy && st && !m_err;
    to = m_busy && m_cnt == TO - 1;
    hold = go || (m_busy && !dn && !to);
    fd = pc && !m_busy && !go;
    fe = (lw && !hold) || fd;
    e.tag = tag;
    e.o = {hold || lw, hold || lw, hold, fd, fe, hold, go, m_err};
    e.sc = m_sc;
    e.fc = m_fc;
    if (!r) sb.push_back(e);
    @(negedge clk);
    last_out = {StallF, StallD, StallE, FlushD, FlushE, FlushM, mdGo, mdError};
    if (!r) begin
      check({tag, "_sb"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.tag, 32'(last_out), 32'(e.o));
        check({e.tag, "_sc"}, stallCount, e.sc);
        check({e.tag, "_fc"}, flushCount, e.fc);
      end
    end
    @(posedge clk);
    if (r) begin
      m_busy = 0; m_cnt = 0; m_err = 0; m_sc = '0; m_fc = '0;
    end else begin
`ifdef HAZARD_PERF_EN
      if (hold || lw) m_sc = m_sc + 1;
      if (fd || fe) m_fc = m_fc + 1;
`endif
      if (go) begin
        m_busy = 1; m_cnt = 0;
      end else if (m_busy) begin
        if (!dn && to) m_err = 1;
        if (dn || to) m_busy = 0;
        m_cnt++;
      end
    end
    #1;
  endtask
  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    for (int i = 0; i < 2; i++)
      step("rst", 1, 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
    idle("idle");                        check("idle_c", 32'(last_out), 32'h00);
    step("lu", 0, 5, 0, 5, 1, 0, 0, 0);  check("lu_c", 32'(last_out), 32'hC8);
    idle("lu_next");                     check("lu_next_c", 32'(last_out), 32'h00);
    step("lu_r0", 0, 0, 0, 0, 1, 0, 0, 0); check("lu_r0_c", 32'(last_out), 32'h00);
    step("br", 0, 1, 2, 3, 0, 1, 0, 0);  check("br_c", 32'(last_out), 32'h18);
    step("br_lu", 0, 1, 3, 3, 1, 1, 0, 0); check("br_lu_c", 32'(last_out), 32'hD8);
    step("md_go", 0, 0, 0, 0, 0, 1, 1, 0); check("md_go_c", 32'(last_out), 32'hE6);
    step("md_b0", 0, 0, 0, 0, 0, 0, 0, 0); check("md_b0_c", 32'(last_out), 32'hE4);
    step("md_b1", 0, 0, 0, 0, 0, 0, 0, 0); check("md_b1_c", 32'(last_out), 32'hE4);
    step("md_done", 0, 0, 0, 0, 0, 0, 0, 1); check("md_done_c", 32'(last_out), 32'h00);
    idle("md_after");                    check("md_after_c", 32'(last_out), 32'h00);
    step("dt_go", 0, 0, 0, 0, 0, 0, 1, 0); check("dt_go_c", 32'(last_out), 32'hE6);
    for (int i = 0; i < TO - 1; i++) idle("dt_b");
    step("dt_both", 0, 0, 0, 0, 0, 0, 0, 1); check("dt_both_c", 32'(last_out), 32'h00);
    idle("dt_after");                    check("dt_err_c", 32'(last_out), 32'h00);
    step("to_go", 0, 0, 0, 0, 0, 0, 1, 0); check("to_go_c", 32'(last_out), 32'hE6);
    for (int i = 0; i < TO - 1; i++) begin
      step("to_b", 0, 0, 0, 0, 0, 0, 1, 0); check("to_b_c", 32'(last_out), 32'hE4);
    end
    step("to_hit", 0, 0, 0, 0, 0, 0, 1, 0); check("to_hit_c", 32'(last_out), 32'h00);
    step("to_err", 0, 0, 0, 0, 0, 0, 1, 0); check("to_err_c", 32'(last_out), 32'h01);
    step("to_lu", 0, 7, 0, 7, 1, 0, 1, 0); check("to_lu_c", 32'(last_out), 32'hC9);
    step("rst_err", 1, 0, 0, 0, 0, 0, 0, 0);
    idle("err_clr");                     check("err_clr_c", 32'(last_out), 32'h00);
    for (int i = 0; i < 300; i++)
      step("rnd", $urandom_range(99) < 2, 5'($urandom_range(3)), 5'($urandom_range(3)),
           5'($urandom_range(3)), 1'($urandom), $urandom_range(3) == 0,
           $urandom_range(9) == 0, $urandom_range(6) == 0);
    step("rb_rst", 1, 0, 0, 0, 0, 0, 0, 0);
    step("rb_go", 0, 0, 0, 0, 0, 0, 1, 0);
    idle("rb_b0");
    idle("rb_b1");
    step("rb_rst_done", 1, 0, 0, 0, 0, 0, 0, 1);
    idle("rb_after");                    check("rb_after_c", 32'(last_out), 32'h00);
    check("rb_sc0", stallCount, 32'd0);
    check("rb_fc0", flushCount, 32'd0);
    idle("rb_run");                      check("rb_run_c", 32'(last_out), 32'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
